mux_8_to_1: RTL and testbench
=============================

# mux_8_to_1

Selects one bit of an 8-bit input bus under control of a 3-bit select and presents it both combinationally and as a registered, valid-qualified copy. Used wherever a single status or data bit must be picked from an 8-bit vector. The combinational path gives zero-latency selection. The registered path gives a clean, clock-aligned sample for downstream synchronous logic.

## Interface
Parameters:
- NUM_IN, 8, number of selectable inputs; fixed at 8 for this block.
- SEL_W, 3, select width; must equal clog2(NUM_IN).

Ports:
- clk  input  1  rising-edge clock for all registered state.
- rst  input  1  reset, synchronous and active-high.
- in  input  8  data vector; bit i is selected when sel == i.
- sel  input  3  select index, binary-coded, 0..7.
- en  input  1  sample strobe for the registered path.
- out  output  1  combinational selection, in[sel].
- out_q  output  1  registered selection.
- sel_q  output  3  select value captured with out_q.
- out_valid  output  1  high when out_q holds a sample taken since reset.

## Operation
- Combinational path:
  - out = in[sel] at all times, independent of clk, rst and en.
  - Every sel code 0..7 is legal; there is no out-of-range case.
  - Decode is one-hot:
    - sel 000 -> in[0], 001 -> in[1], 010 -> in[2], 011 -> in[3].
    - sel 100 -> in[4], 101 -> in[5], 110 -> in[6], 111 -> in[7].
- Registered path:
  - On a rising clk edge with rst = 0 and en = 1, the block loads:
    - out_q <= in[sel]
    - sel_q <= sel
    - out_valid <= 1
  - On a rising edge with rst = 0 and en = 0, out_q, sel_q and out_valid hold their values.
- Reset:
  - On a rising edge with rst = 1: out_q <= 0, sel_q <= 000, out_valid <= 0.
  - rst has priority over en.
  - out is not affected by rst.
- X handling:
  - If sel contains X/Z, out is X.
  - A registered sample taken while sel contains X/Z is X; no X-masking logic is used.
- No other state exists. There is no handshake beyond en and out_valid.

## Timing
- out: zero-cycle latency, purely combinational from in and sel.
- out_q, sel_q: one-cycle latency; they reflect in and sel as sampled at the en-qualified rising edge.
- out_valid:
  - Rises at the first en-qualified edge after reset.
  - Stays high until the next reset.
- Reset is synchronous: an rst pulse that does not span a rising clk edge has no effect.
- Reset mid-operation: a sample and a reset at the same edge resolve to the reset values.
- Simultaneous changes of in and sel: out settles to the new in[new sel] within the same delta/combinational evaluation.

## Test plan
- One-hot walk, combinational:
  - Stimulus: apply in = 1 << k with sel = k for k = 0..7, holding each step 10 time units.
  - Required response: out = 1 at every step. Check the sequence 00000001/000, 00000010/001, … 10000000/111.
- Off-selection check:
  - Stimulus: in = 8'b11111110 with sel = 000.
  - Required response: out = 0.
  - Stimulus: sweep sel 001..111 with the same in.
  - Required response: out = 1 for each.
- Registered capture:
  - Stimulus: rst high for 2 edges, then rst = 0, en = 1, in = 8'b00100000, sel = 101.
  - Required response: after the next edge, out_q = 1, sel_q = 101, out_valid = 1.
- Hold:
  - Stimulus: after the capture above, set en = 0, then change to in = 0, sel = 000 for 3 edges.
  - Required response: out_q stays 1, sel_q stays 101, out_valid stays 1. out follows to 0 immediately.
- Reset priority:
  - Stimulus: rst = 1 and en = 1 at the same edge, with in = 8'hFF.
  - Required response: out_q = 0, sel_q = 000, out_valid = 0. out = 1 throughout.
- Sync reset:
  - Stimulus: a rst glitch between edges.
  - Required response: no change to out_q, sel_q or out_valid.

Source files
------------

// File: rtl/mux_8_to_1.sv
// mux_8_to_1: picks one bit of an 8-bit vector by a 3-bit select.
// A combinational copy gives zero-latency selection; a registered,
// valid-qualified copy gives a clock-aligned sample for synchronous logic.
module mux_8_to_1 #(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] in,
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic              out,
    output logic              out_q,
    output logic [SEL_W-1:0]  sel_q,
    output logic              out_valid
);

    // One-hot decode of sel. A shift keeps X/Z on sel propagating to every
    // decode bit, so out goes X instead of silently picking an input.
    logic [NUM_IN-1:0] sel_onehot;
    logic [NUM_IN-1:0] sel_base;

    assign sel_base = {{(NUM_IN - 1) {1'b0}}, 1'b1};

    // Decode the select into a one-hot mask.
    always_comb begin
        sel_onehot = sel_base << sel;
    end

    // Combinational selection: AND-OR of the input bus with the one-hot mask.
    always_comb begin
        out = |(in & sel_onehot);
    end

    // Registered sample: reset wins over en; en=0 holds all state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= 1'b0;
            sel_q     <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_q     <= out;
            sel_q     <= sel;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_8_to_1.sv
// Self-checking bench for mux_8_to_1. Expected values are pushed to a
// scoreboard queue when stimulus is applied and popped when the DUT output
// is sampled.
module tb_mux_8_to_1;

    logic       clk;
    logic       rst;
    logic [7:0] in_bus;
    logic [2:0] sel;
    logic       en;
    logic       out;
    logic       out_q;
    logic [2:0] sel_q;
    logic       out_valid;

    // Reference state for the registered path
    logic       m_out_q;
    logic [2:0] m_sel_q;
    logic       m_valid;

    // Scoreboard entries: {out_q, sel_q, out_valid} or {4'b0, out}
    logic [4:0] sb_q[$];
    logic [4:0] exp_v;
    logic [4:0] act_v;

    int n_cmp;
    int n_bad;

    mux_8_to_1 #(
        .NUM_IN(8),
        .SEL_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_bus),
        .sel      (sel),
        .en       (en),
        .out      (out),
        .out_q    (out_q),
        .sel_q    (sel_q),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge: predict the registered state from the
    // current inputs, queue it, then wait for the edge and settle.
    task automatic tick();
        logic [7:0] tmp;
        tmp = in_bus;
        if (rst) begin
            m_out_q = 1'b0;
            m_sel_q = 3'd0;
            m_valid = 1'b0;
        end else if (en) begin
            m_out_q = tmp[sel];
            m_sel_q = sel;
            m_valid = 1'b1;
        end
        sb_q.push_back({m_out_q, m_sel_q, m_valid});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        void'(sb_q.pop_front());
        exp_v = sb_q.pop_front();
        act_v = {out_q, sel_q, out_valid};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL reset_state: got %b required %b", act_v, exp_v);
        end
    endtask

    task automatic test_onehot_walk();
        for (int k = 0; k < 8; k++) begin
            in_bus = 8'd1 << k;
            sel    = 3'(k);
            sb_q.push_back(5'b00001);
            #10;
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({4'b0, out} !== exp_v) begin
                n_bad++;
                $display("FAIL onehot_walk in=%b sel=%0d: got %b required %b",
                         in_bus, k, out, exp_v[0]);
            end
        end
    endtask

    task automatic test_off_select();
        in_bus = 8'b1111_1110;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            sb_q.push_back({4'b0, (s != 0)});
            #1;
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({4'b0, out} !== exp_v) begin
                n_bad++;
                $display("FAIL off_select sel=%0d: got %b required %b", s, out, exp_v[0]);
            end
        end
    endtask

    task automatic test_capture();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        void'(sb_q.pop_front());
        void'(sb_q.pop_front());
        rst    = 1'b0;
        en     = 1'b1;
        in_bus = 8'b0010_0000;
        sel    = 3'b101;
        tick();
        exp_v = sb_q.pop_front();
        act_v = {out_q, sel_q, out_valid};
        n_cmp++;
        if (act_v !== 5'b1_101_1 || act_v !== exp_v) begin
            n_bad++;
            $display("FAIL capture: got %b required %b", act_v, exp_v);
        end
    endtask

    task automatic test_hold();
        en     = 1'b0;
        in_bus = 8'h00;
        sel    = 3'b000;
        #1;
        n_cmp++;
        if (out !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_comb_follow: got %b required 0", out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = sb_q.pop_front();
            act_v = {out_q, sel_q, out_valid};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL hold edge %0d: got %b required %b", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_priority();
        in_bus = 8'hFF;
        sel    = 3'b011;
        en     = 1'b1;
        rst    = 1'b1;
        #1;
        n_cmp++;
        if (out !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_prio_out_before: got %b required 1", out);
        end
        tick();
        exp_v = sb_q.pop_front();
        act_v = {out_q, sel_q, out_valid};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL rst_priority: got %b required %b", act_v, exp_v);
        end
        n_cmp++;
        if (out !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_prio_out_after: got %b required 1", out);
        end
        rst = 1'b0;
    endtask

    task automatic test_sync_reset();
        // Load a known sample first
        rst    = 1'b0;
        en     = 1'b1;
        in_bus = 8'h04;
        sel    = 3'b010;
        tick();
        void'(sb_q.pop_front());
        en = 1'b0;
        // Glitch rst entirely between edges
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        exp_v = sb_q.pop_front();
        act_v = {out_q, sel_q, out_valid};
        n_cmp++;
        if (act_v !== exp_v || act_v !== 5'b1_010_1) begin
            n_bad++;
            $display("FAIL sync_reset_glitch: got %b required %b", act_v, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tmp;
        for (int i = 0; i < 40; i++) begin
            in_bus = 8'($urandom);
            sel    = 3'($urandom_range(0, 7));
            en     = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 15) == 0);
            tmp    = in_bus;
            sb_q.push_back({4'b0, tmp[sel]});
            #1;
            exp_v = sb_q.pop_front();
            n_cmp++;
            if ({4'b0, out} !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_comb %0d: got %b required %b", i, out, exp_v[0]);
            end
            tick();
            exp_v = sb_q.pop_front();
            act_v = {out_q, sel_q, out_valid};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_reg %0d: got %b required %b", i, act_v, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_out_q = 1'b0;
        m_sel_q = 3'd0;
        m_valid = 1'b0;
        rst     = 1'b1;
        en      = 1'b0;
        in_bus  = 8'h00;
        sel     = 3'd0;

        test_reset();
        test_onehot_walk();
        test_off_select();
        test_capture();
        test_hold();
        test_reset_priority();
        test_sync_reset();
        test_back_to_back();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
